mem_line_server: RTL and testbench

MEM_LINE_SERVER -- requirements
Module: mem_line_server

---
 rtl/mem_line_server_pkg.sv | 39 +++
 rtl/mem_line_server_if.sv | 44 ++++
 rtl/mem_line_array.sv | 35 +++
 rtl/mem_line_server.sv | 124 ++++++++++++
 tb/tb_mem_line_server.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_line_server_pkg.sv
//------------------------------------------------------------------------------
// mem_line_server_pkg
// Shared definitions for the two-port line server: widths, FSM state
// encodings, requester ids and the round-robin pick function.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mem_line_server_pkg;

  localparam int LINE_W = 128;
  localparam int ADDR_W = 20;
  // LATENCY is limited to 1..15, so a 4-bit countdown is enough
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    MS_IDLE    = 2'd0,
    MS_BUSY    = 2'd1,
    MS_RESPOND = 2'd2
  } ms_state_e;

  typedef enum logic {
    REQ_IC = 1'b0,
    REQ_DC = 1'b1
  } req_id_e;

  // Round-robin choice. On a tie the requester that was not granted last
  // wins. The result is meaningless when neither request is high.
  function automatic req_id_e rr_pick(input logic ic_req, input logic dc_req,
                                      input req_id_e last);
    if (ic_req && (!dc_req || (last == REQ_DC))) begin
      return REQ_IC;
    end
    return REQ_DC;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_line_server_if.sv
//------------------------------------------------------------------------------
// mem_line_server_if
// Request/response bundle between the two caches (master side) and the line
// server (slave side).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mem_line_server_if;
  import mem_line_server_pkg::*;

  // instruction-cache side
  logic              ic_req_in;
  logic              ic_we_in;
  logic [ADDR_W-1:0] ic_addr_in;
  logic [LINE_W-1:0] ic_data_in;
  logic              ic_ready_out;
  logic [LINE_W-1:0] ic_data_out;

  // data-cache side
  logic              dc_req_in;
  logic              dc_we_in;
  logic [ADDR_W-1:0] dc_addr_in;
  logic [LINE_W-1:0] dc_data_in;
  logic              dc_ready_out;
  logic [LINE_W-1:0] dc_data_out;

  modport master (
    output ic_req_in, ic_we_in, ic_addr_in, ic_data_in,
    input  ic_ready_out, ic_data_out,
    output dc_req_in, dc_we_in, dc_addr_in, dc_data_in,
    input  dc_ready_out, dc_data_out
  );

  modport slave (
    input  ic_req_in, ic_we_in, ic_addr_in, ic_data_in,
    output ic_ready_out, ic_data_out,
    input  dc_req_in, dc_we_in, dc_addr_in, dc_data_in,
    output dc_ready_out, dc_data_out
  );

endinterface

`default_nettype wire

// File: rtl/mem_line_array.sv
//------------------------------------------------------------------------------
// mem_line_array
// NUM_LINES x 128-bit line store: combinational read, synchronous write.
// Contents are deliberately not reset.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_line_array
  import mem_line_server_pkg::*;
#(
  parameter int NUM_LINES = 256
) (
  input  wire logic                         clk,
  input  wire logic                         we_i,
  input  wire logic [$clog2(NUM_LINES)-1:0] waddr_i,
  input  wire logic [LINE_W-1:0]            wdata_i,
  input  wire logic [$clog2(NUM_LINES)-1:0] raddr_i,
  output logic      [LINE_W-1:0]            rdata_o
);

  logic [LINE_W-1:0] mem_q [NUM_LINES];

  // Single write port, committed on the rising edge
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/mem_line_server.sv
//------------------------------------------------------------------------------
// mem_line_server
// Serves 128-bit line reads/writes to an instruction and a data cache with a
// fixed LATENCY, round-robin arbitration and abort when the owner drops req.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_line_server
  import mem_line_server_pkg::*;
#(
  parameter int LATENCY   = 4,    // 1..15
  parameter int NUM_LINES = 256   // power of two
) (
  input  wire logic         clk,
  input  wire logic         reset,
  mem_line_server_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_LINES);

  ms_state_e         state_q;
  req_id_e           owner_q;
  req_id_e           last_q;
  logic              we_q;
  logic [IDX_W-1:0]  idx_q;
  logic [LINE_W-1:0] wdata_q;
  logic [CNT_W-1:0]  cnt_q;

  req_id_e           gnt_id;
  logic              any_req;
  logic              owner_req;
  logic              sel_we;
  logic [IDX_W-1:0]  sel_idx;
  logic [LINE_W-1:0] sel_data;
  logic              serve;
  logic              mem_we;
  logic [LINE_W-1:0] rd_line;
  logic              ic_ready;
  logic              dc_ready;

  // Word bits [1:0] and bits above the line index alias by design
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.ic_addr_in, bus.dc_addr_in};

  assign any_req   = bus.ic_req_in | bus.dc_req_in;
  assign gnt_id    = rr_pick(bus.ic_req_in, bus.dc_req_in, last_q);
  assign sel_we    = (gnt_id == REQ_IC) ? bus.ic_we_in : bus.dc_we_in;
  assign sel_idx   = (gnt_id == REQ_IC) ? bus.ic_addr_in[2 +: IDX_W]
                                        : bus.dc_addr_in[2 +: IDX_W];
  assign sel_data  = (gnt_id == REQ_IC) ? bus.ic_data_in : bus.dc_data_in;
  assign owner_req = (owner_q == REQ_IC) ? bus.ic_req_in : bus.dc_req_in;

  // Sequencer: grant in IDLE, count down in BUSY (abort on dropped req),
  // then a single RESPOND cycle that always returns to IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MS_IDLE;
      owner_q <= REQ_IC;
      last_q  <= REQ_DC;          // ic wins the first tie
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        MS_IDLE: begin
          if (any_req) begin
            state_q <= MS_BUSY;
            owner_q <= gnt_id;
            last_q  <= gnt_id;
            we_q    <= sel_we;
            idx_q   <= sel_idx;
            wdata_q <= sel_data;
            cnt_q   <= CNT_W'(LATENCY - 1);
          end
        end
        MS_BUSY: begin
          if (!owner_req) begin
            state_q <= MS_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == '0) begin
            state_q <= MS_RESPOND;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        MS_RESPOND: begin
          state_q <= MS_IDLE;
        end
        default: begin
          state_q <= MS_IDLE;
        end
      endcase
    end
  end

  // The owner is served only if it still holds req during RESPOND; the write
  // lands on the edge that closes that cycle. State is cleared asynchronously,
  // so ready and data fall as soon as reset rises.
  assign serve    = (state_q == MS_RESPOND) && owner_req;
  assign mem_we   = serve && we_q;
  assign ic_ready = serve && (owner_q == REQ_IC);
  assign dc_ready = serve && (owner_q == REQ_DC);

  mem_line_array #(
    .NUM_LINES (NUM_LINES)
  ) u_array (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (idx_q),
    .wdata_i (wdata_q),
    .raddr_i (idx_q),
    .rdata_o (rd_line)
  );

  assign bus.ic_ready_out = ic_ready;
  assign bus.dc_ready_out = dc_ready;
  assign bus.ic_data_out  = (ic_ready && !we_q) ? rd_line : '0;
  assign bus.dc_data_out  = (dc_ready && !we_q) ? rd_line : '0;

endmodule

`default_nettype wire

// File: tb/tb_mem_line_server.sv
//------------------------------------------------------------------------------
// tb_mem_line_server
// Scoreboard bench for mem_line_server (LATENCY=4, NUM_LINES=256) plus a
// small LATENCY=1 / NUM_LINES=16 instance.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_line_server;
  import mem_line_server_pkg::*;

  localparam int LAT = 4;
  localparam int NL  = 256;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  // cycle number of the clock period in progress
  always @(posedge clk) cyc <= cyc + 1;

  mem_line_server_if bus ();
  mem_line_server_if bus1 ();

  mem_line_server #(.LATENCY(LAT), .NUM_LINES(NL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  mem_line_server #(.LATENCY(1), .NUM_LINES(16)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  typedef struct {
    bit           port;   // 0 = ic, 1 = dc
    logic [127:0] data;
    int           cyc;
  } exp_t;

  typedef struct {
    logic         we;
    logic [19:0]  addr;
    logic [127:0] data;
  } txn_t;

  exp_t         sb[$];
  txn_t         ic_tq[$];
  txn_t         dc_tq[$];
  logic [127:0] model [NL];
  exp_t         mon_e;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic txn_t mk(input logic we, input logic [19:0] a, input logic [127:0] d);
    txn_t t;
    t.we = we; t.addr = a; t.data = d;
    return t;
  endfunction

  // Record the response a transaction must produce; writes update the model
  task automatic expect_txn(input bit port, input logic we, input logic [19:0] a,
                            input logic [127:0] d, input int at);
    exp_t e;
    e.port = port;
    e.cyc  = at;
    if (we) begin
      e.data = '0;
      model[a[9:2]] = d;
    end else begin
      e.data = model[a[9:2]];
    end
    sb.push_back(e);
  endtask

  task automatic set_port(input bit port, input logic req, input logic we,
                          input logic [19:0] a, input logic [127:0] d);
    if (!port) begin
      bus.ic_req_in = req; bus.ic_we_in = we; bus.ic_addr_in = a; bus.ic_data_in = d;
    end else begin
      bus.dc_req_in = req; bus.dc_we_in = we; bus.dc_addr_in = a; bus.dc_data_in = d;
    end
  endtask

  function automatic logic rdy(input bit port);
    return port ? bus.dc_ready_out : bus.ic_ready_out;
  endfunction

  // Issue the port's queued transactions back to back, holding req through
  // the ready cycle and switching to the next one after the closing edge
  task automatic run_port(input bit port);
    txn_t t;
    int   guard;
    while ((port ? dc_tq.size() : ic_tq.size()) != 0) begin
      if (port) t = dc_tq.pop_front();
      else      t = ic_tq.pop_front();
      set_port(port, 1'b1, t.we, t.addr, t.data);
      guard = 0;
      do begin
        @(posedge clk); #1;
        guard++;
      end while (!rdy(port) && guard < 60);
      if (!rdy(port)) chk(port ? "dc_timeout" : "ic_timeout", 128'd0, 128'd1);
      @(posedge clk); #1;
    end
    set_port(port, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic single(input bit port, input logic we, input logic [19:0] a,
                        input logic [127:0] d);
    @(negedge clk);
    expect_txn(port, we, a, d, cyc + 1 + LAT);
    if (port) dc_tq.push_back(mk(we, a, d));
    else      ic_tq.push_back(mk(we, a, d));
    run_port(port);
  endtask

  // LATENCY=1 instance: ready must appear in the cycle after the grant cycle
  task automatic l1_txn(input logic we, input logic [19:0] a, input logic [127:0] d,
                        input logic [127:0] exp_data);
    int c;
    int guard;
    @(negedge clk);
    c = cyc;
    bus1.dc_req_in = 1'b1; bus1.dc_we_in = we; bus1.dc_addr_in = a; bus1.dc_data_in = d;
    guard = 0;
    do begin
      @(posedge clk); #1;
      guard++;
    end while (!bus1.dc_ready_out && guard < 20);
    chk("l1_ready", {127'd0, bus1.dc_ready_out}, 128'd1);
    chk("l1_cycle", cyc, c + 2);
    chk("l1_data", bus1.dc_data_out, exp_data);
    @(posedge clk); #1;
    bus1.dc_req_in = 1'b0;
  endtask

  // Scoreboard monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (bus.ic_ready_out || bus.dc_ready_out) begin
      chk("dual_ready", {127'd0, bus.ic_ready_out & bus.dc_ready_out}, 128'd0);
      if (sb.size() == 0) begin
        chk("unexpected_ready", 128'd1, 128'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("port", {127'd0, bus.dc_ready_out}, {127'd0, mon_e.port});
        chk("data", bus.dc_ready_out ? bus.dc_data_out : bus.ic_data_out, mon_e.data);
        chk("latency", cyc, mon_e.cyc);
        chk("other_data", bus.dc_ready_out ? bus.ic_data_out : bus.dc_data_out, 128'd0);
      end
    end else begin
      chk("idle_data", bus.ic_data_out | bus.dc_data_out, 128'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int c;
    int guard;
    logic [127:0] a5  = {16{8'hA5}};
    logic [127:0] old = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;

    set_port(1'b0, 1'b0, 1'b0, '0, '0);
    set_port(1'b1, 1'b0, 1'b0, '0, '0);
    bus1.ic_req_in = 1'b0; bus1.ic_we_in = 1'b0; bus1.ic_addr_in = '0; bus1.ic_data_in = '0;
    bus1.dc_req_in = 1'b0; bus1.dc_we_in = 1'b0; bus1.dc_addr_in = '0; bus1.dc_data_in = '0;

    // outputs while reset is held
    #1;
    chk("rst_ic_ready", {127'd0, bus.ic_ready_out}, 128'd0);
    chk("rst_dc_ready", {127'd0, bus.dc_ready_out}, 128'd0);
    chk("rst_data", bus.ic_data_out | bus.dc_data_out, 128'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // tie from reset: ic first, dc wins the tie formed by ic's follow-on request
    @(negedge clk);
    c = cyc;
    ic_tq.push_back(mk(1'b1, 20'h00010, 128'h11));
    ic_tq.push_back(mk(1'b1, 20'h00014, 128'h22));
    dc_tq.push_back(mk(1'b1, 20'h00020, 128'h33));
    expect_txn(1'b0, 1'b1, 20'h00010, 128'h11, c + 1 + LAT);
    expect_txn(1'b1, 1'b1, 20'h00020, 128'h33, c + 3 + 2 * LAT);
    expect_txn(1'b0, 1'b1, 20'h00014, 128'h22, c + 5 + 3 * LAT);
    fork
      run_port(1'b0);
      run_port(1'b1);
    join
    single(1'b1, 1'b0, 20'h00010, '0);
    single(1'b0, 1'b0, 20'h00014, '0);
    single(1'b0, 1'b0, 20'h00020, '0);

    // single write then read
    single(1'b1, 1'b1, 20'h00040, a5);
    single(1'b1, 1'b0, 20'h00040, '0);

    // abort: req dropped in the second BUSY cycle
    single(1'b1, 1'b1, 20'h00080, old);
    @(negedge clk);
    set_port(1'b1, 1'b1, 1'b1, 20'h00080, ~old);
    @(negedge clk);
    @(negedge clk);
    set_port(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (LAT + 4) @(negedge clk);
    single(1'b1, 1'b0, 20'h00080, '0);

    // write-back then allocate with req held across RESPOND
    single(1'b0, 1'b1, 20'h00200, 128'hFEED_0200);
    @(negedge clk);
    c = cyc;
    dc_tq.push_back(mk(1'b1, 20'h00100, 128'hBEEF_0100));
    dc_tq.push_back(mk(1'b0, 20'h00200, '0));
    expect_txn(1'b1, 1'b1, 20'h00100, 128'hBEEF_0100, c + 1 + LAT);
    expect_txn(1'b1, 1'b0, 20'h00200, '0, c + 3 + 2 * LAT);
    run_port(1'b1);

    // aliasing modulo NUM_LINES
    single(1'b0, 1'b1, 20'h00040, 128'hCAFE_0440);
    single(1'b1, 1'b0, 20'h00440, '0);

    // reset during BUSY of a write
    single(1'b0, 1'b1, 20'h00300, 128'h0300_AAAA);
    @(negedge clk);
    set_port(1'b1, 1'b1, 1'b1, 20'h00300, 128'h0300_BBBB);
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("busy_rst_ready", {126'd0, bus.ic_ready_out, bus.dc_ready_out}, 128'd0);
    chk("busy_rst_data", bus.ic_data_out | bus.dc_data_out, 128'd0);
    set_port(1'b1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    reset = 1'b0;

    // reset inside RESPOND of an ic write: ready falls at once, no commit
    @(negedge clk);
    c = cyc;
    set_port(1'b0, 1'b1, 1'b1, 20'h00300, 128'h0300_CCCC);
    guard = 0;
    do begin
      @(posedge clk); #1;
      guard++;
    end while (!bus.ic_ready_out && guard < 60);
    chk("resp_pre_ready", {127'd0, bus.ic_ready_out}, 128'd1);
    chk("resp_pre_cycle", cyc, c + 1 + LAT);
    #1 reset = 1'b1;
    #1;
    chk("resp_rst_ready", {127'd0, bus.ic_ready_out}, 128'd0);
    chk("resp_rst_data", bus.ic_data_out, 128'd0);
    set_port(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    reset = 1'b0;

    // after reset the pointer favours ic again; line 0x300 kept its old data
    @(negedge clk);
    c = cyc;
    ic_tq.push_back(mk(1'b0, 20'h00300, '0));
    dc_tq.push_back(mk(1'b0, 20'h00040, '0));
    expect_txn(1'b0, 1'b0, 20'h00300, '0, c + 1 + LAT);
    expect_txn(1'b1, 1'b0, 20'h00040, '0, c + 3 + 2 * LAT);
    fork
      run_port(1'b0);
      run_port(1'b1);
    join

    // LATENCY=1, NUM_LINES=16: 0x040 aliases onto line 0
    l1_txn(1'b1, 20'h00000, 128'h5151_0000, 128'd0);
    l1_txn(1'b0, 20'h00040, '0, 128'h5151_0000);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
